// File: rtl/cam_pkg.sv
// cam_pkg: shared types and header/trailer field layout for the CAM result packer.
package cam_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, TRAILER} state_t;

    localparam logic [7:0] TRAILER_MARKER = 8'hA5;
    localparam int HDR_OP_LSB = 0;
    localparam int HDR_N_LSB  = 32;
    localparam int HDR_N_W    = 30;

    typedef struct packed {
        logic        hit;
        logic [30:0] addr;
    } result_word_t;

endpackage

// File: rtl/cam_result_packer_if.sv
// cam_result_packer_if: one AXI-stream style link (TDATA/TVALID/TREADY).
//   master: drives TDATA, TVALID; samples TREADY
//   slave : samples TDATA, TVALID; drives TREADY
interface cam_result_packer_if #(parameter int W = 512);
    logic [W-1:0] TDATA;
    logic         TVALID;
    logic         TREADY;
    modport master (output TDATA, output TVALID, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/cam_lane_compactor.sv
// cam_lane_compactor: packs the hit words of one beat into the low lanes, keeping lane order.
//   words_i  : LANES result words of one input beat
//   packed_o : hit words in ascending lane order from lane 0, unused lanes zero
//   pop_o    : number of hit words
module cam_lane_compactor
    import cam_pkg::*;
#(
    parameter int LANES = 16
) (
    input  result_word_t [LANES-1:0]         words_i,
    output result_word_t [LANES-1:0]         packed_o,
    output logic [$clog2(LANES+1)-1:0]       pop_o
);

    localparam int PW = $clog2(LANES + 1);

    // Running prefix count gives each hit word its destination lane.
    always_comb begin
        logic [PW-1:0] pre;
        packed_o = '0;
        pre      = '0;
        for (int i = 0; i < LANES; i++) begin
            if (words_i[i].hit) begin
                for (int j = 0; j < LANES; j++)
                    if (pre == PW'(j)) packed_o[j] = words_i[i];
                pre = pre + PW'(1);
            end
        end
        pop_o = pre;
    end

endmodule

// File: rtl/cam_result_packer.sv
// cam_result_packer: drops CAM misses, packs hits into dense beats, closes each frame with a trailer.
//   ap_clk   : clock, rising edge
//   ap_rst_n : synchronous active-low reset
//   p1       : slave stream, header beat then N result beats
//   p2       : master stream, packed hit beats then trailer {A5 marker, N, hit count}
module cam_result_packer
    import cam_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 512,
    parameter int RESULT_WIDTH  = 32,
    parameter int OP_CODE_WIDTH = 3
) (
    input logic                 ap_clk,
    input logic                 ap_rst_n,
    cam_result_packer_if.slave  p1,
    cam_result_packer_if.master p2
);

    localparam int LANES = C_DATA_WIDTH / RESULT_WIDTH;
    localparam int ACC   = 2 * LANES - 1;
    localparam int CW    = $clog2(ACC + 1);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    if (HDR_OP_LSB + OP_CODE_WIDTH > HDR_N_LSB) begin : g_bad_hdr
        $error("opcode field overlaps N field");
    end

    state_t                    st_q, st_d;
    result_word_t [ACC-1:0]    acc_q, acc_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [HDR_N_W-1:0]        n_q, n_d;
    logic [31:0]               hit_q, hit_d;
    logic [31:0]               beat_q, beat_d;
    logic                      rdy_q, rdy_d;
    logic                      ovld_q, ovld_d;
    logic [C_DATA_WIDTH-1:0]   odat_q, odat_d;

    result_word_t [LANES-1:0]      words, cw;
    logic [$clog2(LANES+1)-1:0]    pop;
    logic                          out_free, in_fire, drain;
    logic [CW-1:0]                 base;
    logic [C_DATA_WIDTH-1:0]       trl;

    assign words = p1.TDATA;

    cam_lane_compactor #(.LANES(LANES)) u_comp (
        .words_i  (words),
        .packed_o (cw),
        .pop_o    (pop)
    );

    always_comb begin
        out_free = !ovld_q || p2.TREADY;
        in_fire  = p1.TVALID && rdy_q;
        drain    = (cnt_q >= LANES_C) && out_free;
        // Slots at or above cnt are always zero, so the low LANES slots form a ready-made beat.
        base     = cnt_q - (drain ? LANES_C : '0);
        trl      = '0;
        trl[31:0]  = hit_q;
        trl[63:32] = 32'(n_q);
        trl[C_DATA_WIDTH-1 -: 8] = TRAILER_MARKER;
        st_d   = st_q;
        n_d    = n_q;
        hit_d  = hit_q;
        beat_d = beat_q;
        cnt_d  = base;
        acc_d  = drain ? (acc_q >> (LANES * RESULT_WIDTH)) : acc_q;
        ovld_d = ovld_q && !p2.TREADY;
        odat_d = odat_q;
        if (drain) begin
            ovld_d = 1'b1;
            odat_d = acc_q[LANES-1:0];
        end
        case (st_q)
            IDLE: if (in_fire) begin
                n_d    = p1.TDATA[HDR_N_LSB +: HDR_N_W];
                hit_d  = '0;
                beat_d = '0;
                st_d   = (p1.TDATA[HDR_N_LSB +: HDR_N_W] == '0) ? TRAILER : COLLECT;
            end
            COLLECT: if (in_fire) begin
                // Place compacted word j at slot base+j, after whatever a same-cycle drain left.
                for (int s = 0; s < ACC; s++)
                    for (int j = 0; j < LANES; j++)
                        if (CW'(j) < CW'(pop) && CW'(s) == base + CW'(j)) acc_d[s] = cw[j];
                cnt_d  = base + CW'(pop);
                hit_d  = hit_q + 32'(pop);
                beat_d = beat_q + 32'd1;
                st_d   = (beat_q + 32'd1 == 32'(n_q)) ? FLUSH : COLLECT;
            end
            FLUSH: if (cnt_q < LANES_C && out_free) begin
                if (cnt_q != '0) begin
                    ovld_d = 1'b1;
                    odat_d = acc_q[LANES-1:0];
                end
                cnt_d = '0;
                acc_d = '0;
                st_d  = TRAILER;
            end
            TRAILER: if (out_free) begin
                ovld_d = 1'b1;
                odat_d = trl;
                st_d   = IDLE;
            end
            default: st_d = IDLE;
        endcase
        rdy_d = (st_d == IDLE) ||
                (st_d == COLLECT && cnt_d < LANES_C && beat_d != 32'(n_d));
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            st_q   <= IDLE;
            acc_q  <= '0;
            cnt_q  <= '0;
            n_q    <= '0;
            hit_q  <= '0;
            beat_q <= '0;
            rdy_q  <= 1'b0;
            ovld_q <= 1'b0;
            odat_q <= '0;
        end else begin
            st_q   <= st_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            hit_q  <= hit_d;
            beat_q <= beat_d;
            rdy_q  <= rdy_d;
            ovld_q <= ovld_d;
            odat_q <= odat_d;
        end
    end

    assign p1.TREADY = rdy_q;
    assign p2.TVALID = ovld_q;
    assign p2.TDATA  = odat_q;

endmodule

// File: tb/tb_cam_result_packer.sv
// tb_cam_result_packer: directed frames against hand-computed packed beats and trailers.
module tb_cam_result_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_result_packer_if #(.W(512)) p1();
    cam_result_packer_if #(.W(512)) p2();

    cam_result_packer dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .p1       (p1),
        .p2       (p2)
    );

    logic [511:0] q[$];
    int tests = 0;
    int fails = 0;

    always @(negedge clk)
        if (rst_n && p2.TVALID && p2.TREADY) q.push_back(p2.TDATA);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] hdr(input logic [29:0] n);
        logic [511:0] d;
        d = '0;
        d[2:0] = 3'b001;
        d[61:32] = n;
        return d;
    endfunction

    function automatic logic [511:0] mk_beat(input logic [15:0] mask, input logic [30:0] a0);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = {mask[i], a0 + 31'(i)};
        return d;
    endfunction

    function automatic logic [511:0] trl(input logic [31:0] hit, input logic [31:0] n);
        logic [511:0] d;
        d = '0;
        d[31:0] = hit;
        d[63:32] = n;
        d[511:504] = 8'hA5;
        return d;
    endfunction

    function automatic logic [511:0] qget(input int i);
        return (q.size() > i) ? q[i] : 'x;
    endfunction

    task automatic send(input logic [511:0] d, input string tag);
        int k;
        k = 0;
        p1.TDATA = d;
        p1.TVALID = 1'b1;
        while (!p1.TREADY && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 512'(p1.TREADY), 512'd1);
        @(negedge clk);
        p1.TVALID = 1'b0;
    endtask

    task automatic wait_out(input int n, input string tag);
        int k;
        k = 0;
        while (q.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 512'(q.size() >= n), 512'd1);
    endtask

    initial begin
        logic [511:0] e;
        p1.TDATA = '0;
        p1.TVALID = 1'b0;
        p2.TREADY = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_p2_valid", 512'(p2.TVALID), 512'd0);
        chk("rst_p2_data", p2.TDATA, 512'd0);
        chk("rst_p1_ready", 512'(p1.TREADY), 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 512'(p1.TREADY), 512'd1);

        // Frame 1: one all-hit beat, one-cycle latency to the packed beat
        q.delete();
        send(hdr(30'd1), "t1_hdr");
        send(mk_beat(16'hFFFF, 31'd0), "t1_beat");
        chk("t1_lat_k", 512'(p2.TVALID), 512'd0);
        @(negedge clk);
        chk("t1_lat_k1", 512'(p2.TVALID), 512'd1);
        wait_out(2, "t1_wait");
        chk("t1_data", qget(0), mk_beat(16'hFFFF, 31'd0));
        chk("t1_trl", qget(1), trl(32'd16, 32'd1));

        // Frame 2: hits in lanes 3 and 7 of two beats
        q.delete();
        send(hdr(30'd2), "t2_hdr");
        send(mk_beat(16'h0088, 31'd0), "t2_b0");
        send(mk_beat(16'h0088, 31'd0), "t2_b1");
        wait_out(2, "t2_wait");
        e = '0;
        e[31:0]   = 32'h8000_0003;
        e[63:32]  = 32'h8000_0007;
        e[95:64]  = 32'h8000_0003;
        e[127:96] = 32'h8000_0007;
        chk("t2_data", qget(0), e);
        chk("t2_trl", qget(1), trl(32'd4, 32'd2));

        // Frame 3: N=0, trailer right after the header
        q.delete();
        send(hdr(30'd0), "t3_hdr");
        chk("t3_gap", 512'(p2.TVALID), 512'd0);
        @(negedge clk);
        chk("t3_valid", 512'(p2.TVALID), 512'd1);
        chk("t3_trl_now", p2.TDATA, trl(32'd0, 32'd0));
        wait_out(1, "t3_wait");
        chk("t3_trl", qget(0), trl(32'd0, 32'd0));

        // Frame 4: four all-hit beats under 20 cycles of output backpressure
        q.delete();
        @(posedge clk);
        #1 p2.TREADY = 1'b0;
        @(negedge clk);
        send(hdr(30'd4), "t4_hdr");
        send(mk_beat(16'hFFFF, 31'd0), "t4_b0");
        send(mk_beat(16'hFFFF, 31'd16), "t4_b1");
        p1.TDATA = mk_beat(16'hFFFF, 31'd32);
        p1.TVALID = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_stall_ready", 512'(p1.TREADY), 512'd0);
        chk("t4_stall_out", 512'(q.size()), 512'd0);
        chk("t4_held", p2.TDATA, mk_beat(16'hFFFF, 31'd0));
        @(posedge clk);
        #1 p2.TREADY = 1'b1;
        @(negedge clk);
        send(mk_beat(16'hFFFF, 31'd32), "t4_b2");
        send(mk_beat(16'hFFFF, 31'd48), "t4_b3");
        wait_out(5, "t4_wait");
        for (int b = 0; b < 4; b++)
            chk($sformatf("t4_data%0d", b), qget(b), mk_beat(16'hFFFF, 31'(16 * b)));
        chk("t4_trl", qget(4), trl(32'd64, 32'd4));

        // Frame 5: reset with 5 hits accumulated, then a clean one-hit frame
        q.delete();
        send(hdr(30'd2), "t5_hdr");
        send(mk_beat(16'h001F, 31'd0), "t5_b0");
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 512'(p2.TVALID), 512'd0);
        chk("t5_rst_ready", 512'(p1.TREADY), 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send(hdr(30'd1), "t5_hdr2");
        send(mk_beat(16'h0200, 31'h4C), "t5_b1");
        wait_out(2, "t5_wait");
        e = '0;
        e[31:0] = 32'h8000_0055;
        chk("t5_data", qget(0), e);
        chk("t5_trl", qget(1), trl(32'd1, 32'd1));
        repeat (5) @(negedge clk);
        chk("t5_count", 512'(q.size()), 512'd2);

        // Frame 6: three all-miss beats produce only a trailer
        q.delete();
        send(hdr(30'd3), "t6_hdr");
        for (int b = 0; b < 3; b++) send(mk_beat(16'h0000, 31'd0), "t6_beat");
        wait_out(1, "t6_wait");
        chk("t6_trl", qget(0), trl(32'd0, 32'd3));
        repeat (5) @(negedge clk);
        chk("t6_count", 512'(q.size()), 512'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
